// File: rtl/point_lift_if.sv
// Request/response bundle between the point-lift converter and its requester.
// Field widths are fixed by the curve (255-bit coordinates over 2^255-19).
interface point_lift_if;
  logic         i_start;
  logic [254:0] i_x;
  logic [254:0] i_y;
  logic [254:0] o_x;
  logic [254:0] o_y;
  logic [254:0] o_z;
  logic         o_busy;
  logic         o_finished;

  // requester side
  modport master (
    output i_start, i_x, i_y,
    input  o_x, o_y, o_z, o_busy, o_finished
  );

  // converter side
  modport slave (
    input  i_start, i_x, i_y,
    output o_x, o_y, o_z, o_busy, o_finished
  );
endinterface

// File: rtl/point_lift.sv
// Affine -> projective Montgomery-domain lift over q = 2^255 - 19.
// (x, y) -> (x*R, y*R, R) mod q with R = 2^255, computed with one shared
// radix-2 bit-serial Montgomery multiplier against R^2 mod q = 361.
// Each multiply: 255 iteration cycles plus one final reduction cycle.
module point_lift (
  input  logic          i_clk,
  input  logic          i_rst_n,
  point_lift_if.slave   bus
);

  localparam logic [254:0] Q    = 255'd57896044618658097711785492504343953926634992332820282019728792003956564819949;
  localparam logic [254:0] R2   = 255'd361;
  localparam logic [254:0] RMOD = 255'd19;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MUL_X, S_MUL_Y, S_DONE
  } state_t;

  state_t       state_q;
  logic [254:0] x_q, y_q;       // operands, canonical after S_LOAD
  logic [256:0] acc_q;          // Montgomery accumulator, stays below 2Q
  logic [7:0]   cnt_q;          // 0..254 iterate, 255 = final reduction
  logic [254:0] ox_q, oy_q, oz_q;
  logic         busy_q, fin_q;

  logic [254:0] op;
  logic [257:0] sum;
  logic [256:0] acc_d;
  logic [254:0] res_d;
  logic         acc_ge_q;

  // One Montgomery step on the current operand bit, plus the final
  // conditional subtraction. acc < 2Q so the result fits in 255 bits and
  // the subtraction can be done modulo 2^255.
  always_comb begin
    op       = (state_q == S_MUL_X) ? x_q : y_q;
    sum      = {1'b0, acc_q} + (op[cnt_q] ? {3'b000, R2} : 258'd0);
    if (sum[0]) sum = sum + {3'b000, Q};
    acc_d    = sum[257:1];
    acc_ge_q = (acc_q >= {2'b00, Q});
    res_d    = acc_ge_q ? (acc_q[254:0] - Q) : acc_q[254:0];
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      oz_q    <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          fin_q <= 1'b0;
          if (bus.i_start) begin
            x_q     <= bus.i_x;
            y_q     <= bus.i_y;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          // inputs are < 2^255 < 2Q, so one subtraction canonicalizes
          x_q     <= (x_q >= Q) ? (x_q - Q) : x_q;
          y_q     <= (y_q >= Q) ? (y_q - Q) : y_q;
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= S_MUL_X;
        end
        S_MUL_X, S_MUL_Y: begin
          if (cnt_q == 8'd255) begin
            acc_q <= '0;
            cnt_q <= '0;
            if (state_q == S_MUL_X) begin
              ox_q    <= res_d;
              state_q <= S_MUL_Y;
            end else begin
              oy_q    <= res_d;
              oz_q    <= RMOD;
              fin_q   <= 1'b1;
              state_q <= S_DONE;
            end
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          fin_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_x        = ox_q;
  assign bus.o_y        = oy_q;
  assign bus.o_z        = oz_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_finished = fin_q;

endmodule

// File: tb/tb_point_lift.sv
// Scoreboard bench for point_lift: expected (x*R, y*R) pushed at request,
// popped and compared when o_finished fires.
module tb_point_lift;

  localparam logic [511:0] QW = 512'd57896044618658097711785492504343953926634992332820282019728792003956564819949;
  localparam logic [254:0] Q  = 255'd57896044618658097711785492504343953926634992332820282019728792003956564819949;

  typedef struct {
    logic [254:0] x;
    logic [254:0] y;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  point_lift_if bus();
  point_lift dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [254:0] model(input logic [254:0] v);
    logic [511:0] t;
    t = {257'd0, v} % QW;
    t = (t * 512'd19) % QW;
    return t[254:0];
  endfunction

  // Pulse i_start for one edge (E0); returns #1 after E0, i.e. in cycle 1.
  task automatic kick(input logic [254:0] x, input logic [254:0] y);
    exp_t e;
    e.x = model(x);
    e.y = model(y);
    sb.push_back(e);
    bus.i_x = x;
    bus.i_y = y;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  // Called in cycle 1; returns the cycle index in which o_finished is seen.
  task automatic wait_fin(output int cyc, output bit to);
    cyc = 1;
    to  = 1'b0;
    while (bus.o_finished !== 1'b1) begin
      if (cyc >= 700) begin
        to = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    bus.i_start = 1'b0;
    bus.i_x = '0;
    bus.i_y = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.o_x, bus.o_y, bus.o_z} !== '0 || bus.o_busy !== 1'b0 || bus.o_finished !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: x=%0d y=%0d z=%0d busy=%b fin=%b, want all 0",
               bus.o_x, bus.o_y, bus.o_z, bus.o_busy, bus.o_finished);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int cyc; bit to; exp_t e;
    n_cmp++;
    if (bus.o_busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_busy_pre: got %b want 0", bus.o_busy);
    end
    kick(255'd1, 255'd1);
    n_cmp++;
    if (bus.o_busy !== 1'b1) begin
      n_bad++; $display("FAIL basic_busy_c1: got %b want 1", bus.o_busy);
    end
    wait_fin(cyc, to);
    e = sb.pop_front();
    n_cmp++;
    if (to || cyc != 514) begin
      n_bad++; $display("FAIL basic_latency: got cycle %0d (timeout=%0d) want 514", cyc, to);
    end
    n_cmp++;
    if (bus.o_x !== e.x || bus.o_y !== e.y || bus.o_z !== 255'd19 || e.x !== 255'd19) begin
      n_bad++; $display("FAIL basic_result: got %0d/%0d/%0d want 19/19/19", bus.o_x, bus.o_y, bus.o_z);
    end
    n_cmp++;
    if (bus.o_busy !== 1'b1) begin
      n_bad++; $display("FAIL basic_busy_c514: got %b want 1", bus.o_busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.o_busy !== 1'b0 || bus.o_finished !== 1'b0) begin
      n_bad++; $display("FAIL basic_c515: busy=%b fin=%b want 0/0", bus.o_busy, bus.o_finished);
    end
  endtask

  task automatic test_pair(input string nm, input logic [254:0] x, input logic [254:0] y,
                           input logic [254:0] wx, input logic [254:0] wy);
    int cyc; bit to; exp_t e;
    kick(x, y);
    wait_fin(cyc, to);
    e = sb.pop_front();
    n_cmp++;
    if (to || cyc != 514) begin
      n_bad++; $display("FAIL %s_latency: got cycle %0d (timeout=%0d) want 514", nm, cyc, to);
    end
    n_cmp++;
    if (bus.o_x !== wx || bus.o_x !== e.x) begin
      n_bad++; $display("FAIL %s_x: got %0d want %0d", nm, bus.o_x, wx);
    end
    n_cmp++;
    if (bus.o_y !== wy || bus.o_y !== e.y) begin
      n_bad++; $display("FAIL %s_y: got %0d want %0d", nm, bus.o_y, wy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int cyc; bit to; exp_t e;
    logic [254:0] ax, ay;
    ax = 255'd11;
    ay = 255'd13;
    e.x = model(ax); e.y = model(ay);
    sb.push_back(e);
    bus.i_x = ax; bus.i_y = ay;
    bus.i_start = 1'b1;          // held through the whole conversion
    @(posedge clk); #1;
    wait_fin(cyc, to);
    e = sb.pop_front();
    n_cmp++;
    if (to || cyc != 514 || bus.o_x !== e.x || bus.o_y !== e.y) begin
      n_bad++; $display("FAIL b2b_first: cycle %0d x=%0d y=%0d want 514/%0d/%0d", cyc, bus.o_x, bus.o_y, e.x, e.y);
    end
    // start is still high during the o_finished cycle and must be ignored
    bus.i_start = 1'b0;
    bus.i_x = 255'd2; bus.i_y = 255'd3;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.o_busy !== 1'b0 || bus.o_x !== 255'd209 || bus.o_y !== 255'd247) begin
      n_bad++; $display("FAIL b2b_idle_hold: busy=%b x=%0d y=%0d want 0/209/247", bus.o_busy, bus.o_x, bus.o_y);
    end
    kick(255'd2, 255'd3);
    repeat (100) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.o_x !== 255'd209 || bus.o_y !== 255'd247) begin
      n_bad++; $display("FAIL b2b_hold_mid: x=%0d y=%0d want 209/247", bus.o_x, bus.o_y);
    end
    cyc = 101;
    while (bus.o_finished !== 1'b1 && cyc < 700) begin
      @(posedge clk); #1; cyc++;
    end
    e = sb.pop_front();
    n_cmp++;
    if (cyc != 514 || bus.o_x !== 255'd38 || bus.o_y !== 255'd57 || bus.o_x !== e.x) begin
      n_bad++; $display("FAIL b2b_second: cycle %0d x=%0d y=%0d want 514/38/57", cyc, bus.o_x, bus.o_y);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    bit seen;
    bus.i_x = 255'd1234; bus.i_y = 255'd5678;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (299) @(posedge clk);  // now in cycle 300
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.o_x, bus.o_y, bus.o_z} !== '0 || bus.o_busy !== 1'b0 || bus.o_finished !== 1'b0) begin
      n_bad++; $display("FAIL abort_async: x=%0d y=%0d z=%0d busy=%b fin=%b want all 0",
                        bus.o_x, bus.o_y, bus.o_z, bus.o_busy, bus.o_finished);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (300) begin
      @(posedge clk); #1;
      if (bus.o_finished === 1'b1 || bus.o_busy === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++; $display("FAIL abort_no_finish: got activity after abort, want none");
    end
    test_pair("abort_fresh", 255'd5, 255'd7, 255'd95, 255'd133);
  endtask

  task automatic test_random(input int n);
    int cyc; bit to; exp_t e;
    logic [255:0] r;
    int bad_here;
    bad_here = 0;
    for (int k = 0; k < n; k++) begin
      logic [254:0] x, y;
      for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
      x = r[254:0];
      for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
      y = r[254:0];
      if (k == 0) x = Q + 255'd5;
      kick(x, y);
      wait_fin(cyc, to);
      e = sb.pop_front();
      n_cmp++;
      if (to || cyc != 514 || bus.o_x !== e.x || bus.o_y !== e.y || bus.o_z !== 255'd19) begin
        n_bad++;
        if (bad_here < 5)
          $display("FAIL random_%0d: cycle %0d x=%0h y=%0h z=%0d want 514 x=%0h y=%0h z=19",
                   k, cyc, bus.o_x, bus.o_y, bus.o_z, e.x, e.y);
        bad_here++;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pair("canon", Q, {255{1'b1}}, 255'd0, 255'd342);
    test_pair("edge", Q - 255'd1, 255'd1 << 250, Q - 255'd19, 255'd19 << 250);
    test_back_to_back();
    test_reset_abort();
    test_random(100);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
